// File: rtl/dmem_pkg.sv
// Shared constants and FSM encoding for the data-memory responder.
package dmem_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/dmem_array.sv
// ROW_COUNT x DATA_W word storage: synchronous write, combinational read, no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ROW_COUNT = 256,
  localparam int IDX_W = $clog2(ROW_COUNT)
) (
  input  logic              clk,
  input  logic              wen,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [ROW_COUNT];

  always_ff @(posedge clk) begin
    if (wen) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Responder side of the CPU data-memory interface: one request at a time, WAIT_CYCLES wait states.
// Optional out-of-range address checking is enabled by defining DMEM_ADDR_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ROW_COUNT   = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int IDX_W = $clog2(ROW_COUNT);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              lat_wen;
  logic [IDX_W-1:0]  lat_idx;
  logic              lat_bad;
  logic [DATA_W-1:0] lat_wdata;

  logic              req_bad;
  logic              accept;
  logic              go_resp;
  logic              eff_wen;
  logic              eff_bad;
  logic [IDX_W-1:0]  eff_idx;
  logic [DATA_W-1:0] eff_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

`ifdef DMEM_ADDR_CHECK_EN
  assign req_bad = 32'(req_addr) >= 32'(ROW_COUNT);
`else
  logic unused_addr_hi;
  assign req_bad        = 1'b0;
  assign unused_addr_hi = ^req_addr;
`endif

  // With zero wait states the response edge is the accept edge, so the live request is used there.
  always_comb begin
    accept    = (state == IDLE) && req_valid;
    eff_wen   = lat_wen;
    eff_bad   = lat_bad;
    eff_idx   = lat_idx;
    eff_wdata = lat_wdata;
    if (state == IDLE) begin
      eff_wen   = req_wen;
      eff_bad   = req_bad;
      eff_idx   = req_addr[IDX_W-1:0];
      eff_wdata = req_wdata;
    end
    go_resp = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == '0));
    mem_we  = go_resp && eff_wen && !eff_bad;
  end

  dmem_array #(.ROW_COUNT(ROW_COUNT)) u_array (
    .clk   (clk),
    .wen   (mem_we),
    .idx   (eff_idx),
    .wdata (eff_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
      lat_wen    <= 1'b0;
      lat_idx    <= '0;
      lat_bad    <= 1'b0;
      lat_wdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_wen   <= req_wen;
            lat_idx   <= req_addr[IDX_W-1:0];
            lat_bad   <= req_bad;
            lat_wdata <= req_wdata;
            resp_err  <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 1'b1;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
      // Later assignment deliberately overrides the accept-time resp_err clear when WAIT_CYCLES==0.
      if (go_resp) begin
        resp_valid <= 1'b1;
        resp_rdata <= (eff_wen || eff_bad) ? '0 : mem_rdata;
        resp_err   <= eff_bad;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: one zero-wait and one two-wait instance against a word-array model.
module tb_dmem_responder;

  localparam int RC = 256;
`ifdef DMEM_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        req_valid [2];
  logic        req_wen   [2];
  logic [15:0] req_addr  [2];
  logic [15:0] req_wdata [2];
  logic        req_ready [2];
  logic        resp_valid[2];
  logic [15:0] resp_rdata[2];
  logic        resp_err  [2];
  logic        busy      [2];

  int total = 0;
  int bad   = 0;
  int wc [2] = '{0, 2};
  logic [15:0] model [2][RC];

  dmem_responder #(.ROW_COUNT(RC), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_wen(req_wen[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_ready(req_ready[0]), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .busy(busy[0])
  );

  dmem_responder #(.ROW_COUNT(RC), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_wen(req_wen[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_ready(req_ready[1]), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .busy(busy[1])
  );

  // Memory semantics: wrap by ROW_COUNT, out-of-range accesses error out only when checking is built in.
  function automatic void model_access(input int d, input logic wen, input logic [15:0] addr,
                                       input logic [15:0] wdata, output logic [15:0] er, output logic ee);
    int idx;
    bit oob;
    idx = int'(addr) % RC;
    oob = CHK && (int'(addr) >= RC);
    ee  = oob;
    if (wen) begin
      er = 16'h0;
      if (!oob) model[d][idx] = wdata;
    end else begin
      er = oob ? 16'h0 : model[d][idx];
    end
  endfunction

  task automatic run_txn(input int d, input logic wen, input logic [15:0] addr, input logic [15:0] wdata,
                         output int lat, output logic [15:0] rd, output logic er);
    int n;
    lat = -1; rd = '0; er = 1'b0; n = 0;
    @(negedge clk);
    while (req_ready[d] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    req_valid[d] = 1'b1; req_wen[d] = wen; req_addr[d] = addr; req_wdata[d] = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (resp_valid[d] === 1'b1) begin
        lat = k; rd = resp_rdata[d]; er = resp_err[d];
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_wen[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      total++; if (req_ready[d] !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready[%0d]: got %b want 1", d, req_ready[d]); end
      total++; if (resp_valid[d] !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid[%0d]: got %b want 0", d, resp_valid[d]); end
      total++; if (resp_rdata[d] !== 16'h0) begin bad++; $display("[TB] FAIL reset_rdata[%0d]: got %h want 0000", d, resp_rdata[d]); end
      total++; if (resp_err[d] !== 1'b0) begin bad++; $display("[TB] FAIL reset_err[%0d]: got %b want 0", d, resp_err[d]); end
      total++; if (busy[d] !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy[%0d]: got %b want 0", d, busy[d]); end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic preload();
    logic [15:0] er, rd, w;
    logic ee, e;
    int lat;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) begin
        w = 16'($urandom);
        model_access(d, 1'b1, 16'(i), w, er, ee);
        run_txn(d, 1'b1, 16'(i), w, lat, rd, e);
      end
    end
  endtask

  task automatic test_basic();
    logic [15:0] er, rd;
    logic ee, e;
    int lat;
    model_access(1, 1'b1, 16'h0010, 16'hBEEF, er, ee);
    run_txn(1, 1'b1, 16'h0010, 16'hBEEF, lat, rd, e);
    total++; if (lat !== 2) begin bad++; $display("[TB] FAIL basic_wr_lat: got %0d want 2", lat); end
    total++; if (rd !== 16'h0) begin bad++; $display("[TB] FAIL basic_wr_rdata: got %h want 0000", rd); end
    total++; if (e !== 1'b0) begin bad++; $display("[TB] FAIL basic_wr_err: got %b want 0", e); end
    model_access(1, 1'b0, 16'h0010, 16'h0, er, ee);
    run_txn(1, 1'b0, 16'h0010, 16'h0, lat, rd, e);
    total++; if (lat !== 2) begin bad++; $display("[TB] FAIL basic_rd_lat: got %0d want 2", lat); end
    total++; if (rd !== 16'hBEEF) begin bad++; $display("[TB] FAIL basic_rd_rdata: got %h want beef", rd); end
    total++; if (e !== 1'b0) begin bad++; $display("[TB] FAIL basic_rd_err: got %b want 0", e); end
  endtask

  task automatic test_zero_wait();
    logic [15:0] er, rd;
    logic [15:0] exp_q [$];
    logic ee, e;
    int lat, nresp;
    model_access(0, 1'b0, 16'h0007, 16'h0, er, ee);
    run_txn(0, 1'b0, 16'h0007, 16'h0, lat, rd, e);
    total++; if (lat !== 0) begin bad++; $display("[TB] FAIL zw_lat: got %0d want 0", lat); end
    total++; if (rd !== er) begin bad++; $display("[TB] FAIL zw_rdata: got %h want %h", rd, er); end
    // Continuous read stream: accept, RESP, accept, RESP, ...
    @(negedge clk);
    nresp = 0;
    model_access(0, 1'b0, 16'h0001, 16'h0, er, ee); exp_q.push_back(er);
    req_valid[0] = 1'b1; req_wen[0] = 1'b0; req_addr[0] = 16'h0001;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++; if (req_ready[0] !== 1'(i % 2)) begin bad++; $display("[TB] FAIL b2b_ready[%0d]: got %b want %b", i, req_ready[0], 1'(i % 2)); end
      if (resp_valid[0] === 1'b1) begin
        nresp++;
        er = exp_q.pop_front();
        total++; if (resp_rdata[0] !== er) begin bad++; $display("[TB] FAIL b2b_rdata[%0d]: got %h want %h", i, resp_rdata[0], er); end
      end
      if (i == 1 || i == 3) begin
        req_addr[0] = 16'(2 + i / 2);
        model_access(0, 1'b0, req_addr[0], 16'h0, er, ee); exp_q.push_back(er);
      end
      if (i == 5) req_valid[0] = 1'b0;
    end
    total++; if (nresp !== 3) begin bad++; $display("[TB] FAIL b2b_count: got %0d want 3", nresp); end
  endtask

  task automatic test_hold();
    logic [15:0] er, rd, e21, e22;
    logic ee, e;
    int lat, nresp;
    model_access(1, 1'b0, 16'h0020, 16'h0, er, ee);
    model_access(1, 1'b0, 16'h0021, 16'h0, e21, ee);
    model_access(1, 1'b0, 16'h0022, 16'h0, e22, ee);
    @(negedge clk);
    nresp = 0;
    req_valid[1] = 1'b1; req_wen[1] = 1'b0; req_addr[1] = 16'h0020; req_wdata[1] = 16'h0;
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid[1] === 1'b1) nresp++;
      if (k < 2) begin
        total++; if (req_ready[1] !== 1'b0 || busy[1] !== 1'b1 || resp_valid[1] !== 1'b0) begin
          bad++; $display("[TB] FAIL hold_wait[%0d]: got ready=%b busy=%b valid=%b want 0 1 0", k, req_ready[1], busy[1], resp_valid[1]);
        end
        req_addr[1] = 16'(16'h0021 + k); req_wen[1] = 1'b1; req_wdata[1] = 16'($urandom);
      end else if (k == 2) begin
        total++; if (resp_valid[1] !== 1'b1 || req_ready[1] !== 1'b0) begin
          bad++; $display("[TB] FAIL hold_resp: got valid=%b ready=%b want 1 0", resp_valid[1], req_ready[1]);
        end
        total++; if (resp_rdata[1] !== er) begin bad++; $display("[TB] FAIL hold_rdata: got %h want %h", resp_rdata[1], er); end
        req_valid[1] = 1'b0; req_wen[1] = 1'b0;
      end else begin
        total++; if (req_ready[1] !== 1'b1 || busy[1] !== 1'b0) begin
          bad++; $display("[TB] FAIL hold_idle[%0d]: got ready=%b busy=%b want 1 0", k, req_ready[1], busy[1]);
        end
      end
    end
    total++; if (nresp !== 1) begin bad++; $display("[TB] FAIL hold_count: got %0d want 1", nresp); end
    run_txn(1, 1'b0, 16'h0021, 16'h0, lat, rd, e);
    total++; if (rd !== e21) begin bad++; $display("[TB] FAIL hold_no_wr21: got %h want %h", rd, e21); end
    run_txn(1, 1'b0, 16'h0022, 16'h0, lat, rd, e);
    total++; if (rd !== e22) begin bad++; $display("[TB] FAIL hold_no_wr22: got %h want %h", rd, e22); end
  endtask

  task automatic test_reset_abort();
    logic [15:0] old, rd;
    logic ee, e;
    int lat, nresp;
    model_access(1, 1'b0, 16'h0005, 16'h0, old, ee);
    @(negedge clk);
    req_valid[1] = 1'b1; req_wen[1] = 1'b1; req_addr[1] = 16'h0005; req_wdata[1] = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (req_ready[1] !== 1'b1 || resp_valid[1] !== 1'b0 || busy[1] !== 1'b0 || resp_err[1] !== 1'b0) begin
      bad++; $display("[TB] FAIL abort_ctrl: got ready=%b valid=%b busy=%b err=%b want 1 0 0 0", req_ready[1], resp_valid[1], busy[1], resp_err[1]);
    end
    total++; if (resp_rdata[1] !== 16'h0) begin bad++; $display("[TB] FAIL abort_rdata: got %h want 0000", resp_rdata[1]); end
    @(negedge clk);
    rst = 1'b0;
    nresp = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid[1] === 1'b1) nresp++;
    end
    total++; if (nresp !== 0) begin bad++; $display("[TB] FAIL abort_no_resp: got %0d want 0", nresp); end
    run_txn(1, 1'b0, 16'h0005, 16'h0, lat, rd, e);
    total++; if (rd !== old) begin bad++; $display("[TB] FAIL abort_storage: got %h want %h", rd, old); end
  endtask

  task automatic test_wrap();
    logic [15:0] er, rd;
    logic ee, e;
    int lat;
    model_access(1, 1'b1, 16'h0103, 16'hAAAA, er, ee);
    run_txn(1, 1'b1, 16'h0103, 16'hAAAA, lat, rd, e);
    total++; if (e !== 1'(CHK)) begin bad++; $display("[TB] FAIL wrap_wr_err: got %b want %b", e, 1'(CHK)); end
    total++; if (rd !== 16'h0) begin bad++; $display("[TB] FAIL wrap_wr_rdata: got %h want 0000", rd); end
    model_access(1, 1'b0, 16'h0003, 16'h0, er, ee);
    run_txn(1, 1'b0, 16'h0003, 16'h0, lat, rd, e);
    total++; if (rd !== er || e !== 1'b0) begin bad++; $display("[TB] FAIL wrap_rd3: got %h/%b want %h/0", rd, e, er); end
`ifndef DMEM_ADDR_CHECK_EN
    total++; if (rd !== 16'hAAAA) begin bad++; $display("[TB] FAIL wrap_alias: got %h want aaaa", rd); end
`endif
    model_access(1, 1'b0, 16'h0103, 16'h0, er, ee);
    run_txn(1, 1'b0, 16'h0103, 16'h0, lat, rd, e);
    total++; if (rd !== er || e !== ee) begin bad++; $display("[TB] FAIL wrap_rd103: got %h/%b want %h/%b", rd, e, er, ee); end
    model_access(1, 1'b0, 16'h0004, 16'h0, er, ee);
    run_txn(1, 1'b0, 16'h0004, 16'h0, lat, rd, e);
    total++; if (e !== 1'b0 || rd !== er) begin bad++; $display("[TB] FAIL wrap_err_clear: got %h/%b want %h/0", rd, e, er); end
  endtask

  task automatic test_random();
    logic [15:0] er, rd, addr, w;
    logic ee, e, wen;
    int lat, d;
    for (int i = 0; i < 40; i++) begin
      d    = int'($urandom_range(0, 1));
      wen  = 1'($urandom_range(0, 1));
      addr = 16'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) addr[15:8] = 8'($urandom_range(1, 255));
      w = 16'($urandom);
      model_access(d, wen, addr, w, er, ee);
      run_txn(d, wen, addr, w, lat, rd, e);
      total++; if (lat !== wc[d]) begin bad++; $display("[TB] FAIL rand_lat[%0d]: got %0d want %0d", i, lat, wc[d]); end
      total++; if (rd !== er) begin bad++; $display("[TB] FAIL rand_rdata[%0d] @%h: got %h want %h", i, addr, rd, er); end
      total++; if (e !== ee) begin bad++; $display("[TB] FAIL rand_err[%0d] @%h: got %b want %b", i, addr, e, ee); end
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_basic();
    test_zero_wait();
    test_hold();
    test_reset_abort();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
